// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: computes an MD result at launch, holds it for a fixed
// modelled latency, then commits it to HI/LO while stalling dependent decode traffic.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src0,
    input  logic [31:0] src1,
    input  logic        d_use_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

    logic [4:0]  count_reg;
    logic [31:0] pend_hi_reg;
    logic [31:0] pend_lo_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;

    md_op_e      op_dec;
    logic        launch;
    logic        op_multi_cycle;
    logic [63:0] prod_signed;
    logic [63:0] prod_unsigned;
    logic [31:0] quot_signed;
    logic [31:0] rem_signed;
    logic [31:0] quot_unsigned;
    logic [31:0] rem_unsigned;
    logic        div_by_zero;

    assign op_dec = md_op_e'(op);
    assign launch = start && (count_reg == 5'd0);

    // Operands are widened to 64 bits so the product keeps its full upper half.
    assign prod_signed   = $signed({{32{src0[31]}}, src0}) * $signed({{32{src1[31]}}, src1});
    assign prod_unsigned = {32'd0, src0} * {32'd0, src1};

    assign div_by_zero   = (src1 == 32'd0);
    assign quot_signed   = div_by_zero ? 32'd0 : 32'($signed(src0) / $signed(src1));
    assign rem_signed    = div_by_zero ? 32'd0 : 32'($signed(src0) % $signed(src1));
    assign quot_unsigned = div_by_zero ? 32'd0 : src0 / src1;
    assign rem_unsigned  = div_by_zero ? 32'd0 : src0 % src1;

    always_comb begin
        op_multi_cycle = 1'b0;
        case (op_dec)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: op_multi_cycle = 1'b1;
            default:                            op_multi_cycle = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg   <= 5'd0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
        end else if (count_reg != 5'd0) begin
            // Any start seen here is ignored: the unit accepts nothing while counting.
            count_reg <= count_reg - 5'd1;
            if (count_reg == 5'd1) begin
                hi_reg <= pend_hi_reg;
                lo_reg <= pend_lo_reg;
            end
        end else if (launch) begin
            case (op_dec)
                OP_MULT: begin
                    {pend_hi_reg, pend_lo_reg} <= prod_signed;
                    count_reg <= MULT_LOAD;
                end
                OP_MULTU: begin
                    {pend_hi_reg, pend_lo_reg} <= prod_unsigned;
                    count_reg <= MULT_LOAD;
                end
                OP_DIV: begin
                    pend_hi_reg <= div_by_zero ? hi_reg : rem_signed;
                    pend_lo_reg <= div_by_zero ? lo_reg : quot_signed;
                    count_reg   <= DIV_LOAD;
                end
                OP_DIVU: begin
                    pend_hi_reg <= div_by_zero ? hi_reg : rem_unsigned;
                    pend_lo_reg <= div_by_zero ? lo_reg : quot_unsigned;
                    count_reg   <= DIV_LOAD;
                end
                OP_MTHI: hi_reg <= src0;
                OP_MTLO: lo_reg <= src0;
                default: ;
            endcase
        end
    end

    assign busy  = (count_reg != 5'd0);
    // The launch term holds back an MD instruction sitting directly behind mult/div.
    assign stall = d_use_md && (busy || (start && op_multi_cycle));
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: a vector table of back-to-back MD operations plus
// hand-written sequences for MTHI/MTLO, mid-flight reset and start-while-busy.
module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src0;
    logic [31:0] src1;
    logic        d_use_md;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [2:0] MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3, DIVU = 3'd4,
                           MTHI = 3'd5, MTLO = 3'd6;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .src0(src0), .src1(src1),
        .d_use_md(d_use_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        dmd;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller must be at a negedge; returns at the negedge of the first idle cycle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic dmd, output int busy_n, output int stall_n,
                          output logic hold_ok);
        logic [31:0] hi0, lo0;
        hi0 = hi;
        lo0 = lo;
        busy_n = 0;
        stall_n = 0;
        hold_ok = 1'b1;
        start = 1'b1; op = o; src0 = a; src1 = b; d_use_md = dmd;
        #1;
        if (stall) stall_n++;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall) stall_n++;
            if (!busy) break;
            busy_n++;
            if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
        end
        d_use_md = 1'b0;
    endtask

    initial begin
        int bn, sn, ok;
        logic hold_ok;

        vecs[0] = '{MULT,  32'hFFFFFFFE, 32'd3,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,   1'b0, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2] = '{DIV,   32'hFFFFFFF9, 32'd2,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{DIVU,  32'd7,        32'd0,          1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4] = '{DIV,   32'd5,        32'd0,          1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[5] = '{DIVU,  32'd100,      32'd7,          1'b0, 32'd2,        32'd14,       10};
        vecs[6] = '{DIV,   32'd9,        32'hFFFFFFFE,   1'b1, 32'd1,        32'hFFFFFFFC, 10};
        vecs[7] = '{MULT,  32'h7FFFFFFF, 32'h7FFFFFFF,   1'b0, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[8] = '{MULT,  32'hFFFFFFFF, 32'h80000000,   1'b1, 32'h00000000, 32'h80000000, 5};

        reset = 1'b1; start = 1'b0; op = 3'd0; src0 = '0; src1 = '0; d_use_md = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        d_use_md = 1'b0;

        // Vectors run back-to-back: each launches in the first idle cycle of the previous one.
        @(negedge clk);
        for (int v = 0; v < 9; v++) begin
            run_op(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].dmd, bn, sn, hold_ok);
            check($sformatf("v%0d_busy_cycles", v), 64'(bn), 64'(vecs[v].exp_cycles));
            check($sformatf("v%0d_stall_cycles", v), 64'(sn),
                  vecs[v].dmd ? 64'(vecs[v].exp_cycles + 1) : 64'd0);
            check($sformatf("v%0d_hold", v), 64'(hold_ok), 64'd1);
            check($sformatf("v%0d_hi", v), 64'(hi), 64'(vecs[v].exp_hi));
            check($sformatf("v%0d_lo", v), 64'(lo), 64'(vecs[v].exp_lo));
            $display("[TB] vec %0d op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h busy=%0d stall=%0d",
                     v, vecs[v].op, vecs[v].a, vecs[v].b, hi, lo, bn, sn);
        end

        // MTHI then MTLO on consecutive cycles; neither is multi-cycle.
        start = 1'b1; op = MTHI; src0 = 32'h12345678; d_use_md = 1'b1;
        #1 check("mthi_no_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        check("mthi_hi", 64'(hi), 64'h12345678);
        check("mthi_busy", 64'(busy), 64'd0);
        op = MTLO; src0 = 32'h9ABCDEF0;
        @(posedge clk);
        #1;
        check("mtlo_lo", 64'(lo), 64'h9ABCDEF0);
        check("mtlo_hi_kept", 64'(hi), 64'h12345678);
        check("mtlo_busy", 64'(busy), 64'd0);
        start = 1'b0; d_use_md = 1'b0;
        $display("[TB] mthi/mtlo -> hi=0x%08h lo=0x%08h", hi, lo);

        // Reset in the fourth busy cycle of a DIV discards the result.
        @(negedge clk);
        start = 1'b1; op = DIV; src0 = 32'd100; src1 = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_hi", 64'(hi), 64'd0);
        check("rst_mid_lo", 64'(lo), 64'd0);
        ok = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (busy || hi != 32'd0 || lo != 32'd0) ok = 0;
        end
        check("rst_mid_no_commit", 64'(ok), 64'd1);
        $display("[TB] reset mid-div -> hi=0x%08h lo=0x%08h busy=%0d", hi, lo, busy);

        // Start pulses during a MULT must be ignored entirely.
        start = 1'b1; op = MULT; src0 = 32'd3; src1 = 32'd4;
        @(posedge clk);
        #1 start = 1'b0;
        bn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 1) begin start = 1'b1; op = DIV; src0 = 32'd100; src1 = 32'd7; end
            if (i == 2) begin op = MTHI; src0 = 32'hDEADBEEF; end
            if (i == 3) start = 1'b0;
            if (!busy) break;
            bn++;
        end
        start = 1'b0;
        check("busy_start_cycles", 64'(bn), 64'd5);
        check("busy_start_hi", 64'(hi), 64'd0);
        check("busy_start_lo", 64'(lo), 64'd12);
        ok = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy || hi != 32'd0 || lo != 32'd12) ok = 0;
        end
        check("busy_start_no_relaunch", 64'(ok), 64'd1);
        $display("[TB] start-while-busy -> hi=0x%08h lo=0x%08h busy=%0d", hi, lo, bn);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
